// File: rtl/shift_left_logical_iterative_if.sv
// Operand/result handshake bundle for the iterative left shifter.
interface shift_left_logical_iterative_if #(
  parameter int N = 32
) ();
  localparam int L = $clog2(N);

  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in;
  logic [L-1:0] shamt;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out;

  modport master (
    output in_valid, in, shamt, out_ready,
    input  in_ready, out_valid, out
  );

  modport slave (
    input  in_valid, in, shamt, out_ready,
    output in_ready, out_valid, out
  );
endinterface

// File: rtl/shift_left_logical_iterative.sv
// Logical left shift, one binary-weighted stage per clock; result valid L=$clog2(N) cycles after accept.
// Accepts only when idle; a finished result is held in DONE for as long as out_ready stays low.
module shift_left_logical_iterative #(
  parameter int N = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  shift_left_logical_iterative_if.slave bus
);
  localparam int L  = $clog2(N);
  localparam int KW = (L > 1) ? $clog2(L) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  acc_q, acc_d;
  logic [L-1:0]  sh_q, sh_d;
  logic [KW-1:0] k_q, k_d;
  logic [L-1:0]  stage_amt;

  // Stage k moves the value by 2^k; the largest weight 2^(L-1) still fits in L bits.
  assign stage_amt = L'(1) << k_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      sh_q    <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      sh_q    <= sh_d;
      k_q     <= k_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    sh_d    = sh_q;
    k_d     = k_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          acc_d   = bus.in;
          sh_d    = bus.shamt;
          k_d     = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (sh_q[k_q]) begin
          acc_d = acc_q << stage_amt;
        end
        if (k_q == KW'(L - 1)) begin
          state_d = S_DONE;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Handshake outputs come straight from the state register, never from in_valid/out_ready.
  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.out       = acc_q;
endmodule

// File: tb/tb_shift_left_logical_iterative.sv
// Bench: directed literal cases plus randomized N=32 and exhaustive N=8 runs against a latency-level model.
module tb_shift_left_logical_iterative;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  shift_left_logical_iterative_if #(.N(32)) b32 ();
  shift_left_logical_iterative_if #(.N(8))  b8 ();

  shift_left_logical_iterative #(.N(32)) dut32 (.clk(clk), .rst(rst), .bus(b32.slave));
  shift_left_logical_iterative #(.N(8))  dut8  (.clk(clk), .rst(rst), .bus(b8.slave));

  int errs   = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: an accepted operand yields (in * 2^shamt) mod 2^N exactly L edges later,
  // held until out_ready; the block is busy from accept until that result leaves.
  logic [31:0] q32[$];
  logic [7:0]  q8[$];
  bit busy32 = 0, busy8 = 0;
  int age32 = 0, age8 = 0;
  int acc32 = 0, done32 = 0, acc8 = 0, done8 = 0;

  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_out32", b32.out, 0);
      chk("rst_valid32", b32.out_valid, 0);
      chk("rst_ready32", b32.in_ready, 1);
      chk("rst_out8", b8.out, 0);
      chk("rst_valid8", b8.out_valid, 0);
      chk("rst_ready8", b8.in_ready, 1);
      busy32 = 0; busy8 = 0;
      q32.delete(); q8.delete();
      acc32 = done32; acc8 = done8;
    end else begin
      chk("in_ready32", b32.in_ready, !busy32);
      chk("out_valid32", b32.out_valid, busy32 && age32 == 5);
      if (busy32 && age32 == 5) chk("out32", b32.out, q32[0]);
      if (!busy32) begin
        if (b32.in_valid) begin
          busy32 = 1; age32 = 0; acc32++;
          q32.push_back(32'(64'(b32.in) * (64'd1 << b32.shamt)));
        end
      end else if (age32 == 5) begin
        if (b32.out_ready) begin
          busy32 = 0; done32++;
          void'(q32.pop_front());
        end
      end else begin
        age32++;
      end

      chk("in_ready8", b8.in_ready, !busy8);
      chk("out_valid8", b8.out_valid, busy8 && age8 == 3);
      if (busy8 && age8 == 3) chk("out8", b8.out, q8[0]);
      if (!busy8) begin
        if (b8.in_valid) begin
          busy8 = 1; age8 = 0; acc8++;
          q8.push_back(8'(16'(b8.in) * (16'd1 << b8.shamt)));
        end
      end else if (age8 == 3) begin
        if (b8.out_ready) begin
          busy8 = 0; done8++;
          void'(q8.pop_front());
        end
      end else begin
        age8++;
      end
    end
  end

  task automatic send32(input logic [31:0] v, input logic [4:0] s, input int stall,
                        input logic [31:0] lit);
    int n;
    n = 0;
    while (!b32.in_ready && n < 20) begin @(posedge clk); #1; n++; end
    chk("ready32_before_op", b32.in_ready, 1);
    b32.in_valid = 1; b32.in = v; b32.shamt = s; b32.out_ready = 0;
    @(posedge clk); #1;
    b32.in_valid = 0; b32.in = ~v; b32.shamt = ~s;
    n = 0;
    while (!b32.out_valid && n < 20) begin @(posedge clk); #1; n++; end
    chk("latency32", n, 5);
    chk("out32_literal", b32.out, lit);
    for (int i = 0; i < stall; i++) begin
      b32.in_valid = (i == 1); b32.in = $urandom; b32.shamt = 5'($urandom);
      @(posedge clk); #1;
      chk("hold_valid32", b32.out_valid, 1);
      chk("hold_out32", b32.out, lit);
    end
    b32.in_valid = 0; b32.out_ready = 1;
    @(posedge clk); #1;
    b32.out_ready = 0;
    chk("ready32_after_op", b32.in_ready, 1);
    chk("valid32_after_op", b32.out_valid, 0);
  endtask

  initial begin
    int base, cyc;
    b32.in_valid = 0; b32.in = '0; b32.shamt = '0; b32.out_ready = 0;
    b8.in_valid = 0;  b8.in = '0;  b8.shamt = '0;  b8.out_ready = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1;
    chk("ready32_after_reset", b32.in_ready, 1);

    send32(32'h0000_0001, 5'd31, 0, 32'h8000_0000);
    send32(32'hDEAD_BEEF, 5'd0,  0, 32'hDEAD_BEEF);
    send32(32'hFFFF_FFFF, 5'd16, 0, 32'hFFFF_0000);
    send32(32'h1234_5678, 5'd4,  0, 32'h2345_6780);
    send32(32'h0000_00F0, 5'd8,  4, 32'h0000_F000);

    // Reset dropped in the third SHIFT cycle discards the operation.
    b32.in_valid = 1; b32.in = 32'hCAFE_F00D; b32.shamt = 5'd3;
    @(posedge clk); #1;
    b32.in_valid = 0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 0;
    #1;
    chk("midreset_valid32", b32.out_valid, 0);
    chk("midreset_out32", b32.out, 0);
    chk("midreset_ready32", b32.in_ready, 1);
    repeat (2) @(posedge clk);
    #1 rst = 1;
    send32(32'h0000_0003, 5'd1, 0, 32'h0000_0006);

    fork
      begin
        base = acc32; cyc = 0;
        while (acc32 - base < 10000 && cyc < 90000) begin
          b32.in_valid  = ($urandom_range(15) != 0);
          b32.in        = $urandom;
          b32.shamt     = 5'($urandom);
          b32.out_ready = ($urandom_range(7) != 0);
          @(posedge clk); #1; cyc++;
        end
        chk("rand32_ops", (acc32 - base) >= 10000, 1);
        b32.in_valid = 0; b32.out_ready = 1; cyc = 0;
        while (q32.size() != 0 && cyc < 50) begin @(posedge clk); #1; cyc++; end
        chk("drain32", q32.size(), 0);
      end
      begin
        for (int v = 0; v < 256; v++) begin
          for (int s = 0; s < 8; s++) begin
            bit rdy;
            int n;
            if ($urandom_range(7) == 0) begin
              b8.in_valid = 0; b8.out_ready = $urandom_range(1);
              @(posedge clk); #1;
            end
            b8.in_valid = 1; b8.in = 8'(v); b8.shamt = 3'(s);
            n = 0;
            do begin
              rdy = b8.in_ready;
              b8.out_ready = ($urandom_range(3) != 0);
              @(posedge clk); #1; n++;
            end while (!rdy && n < 64);
            if (!rdy) chk("accept8_timeout", 0, 1);
            b8.in_valid = 0;
          end
        end
        b8.out_ready = 1;
        for (int i = 0; i < 50 && q8.size() != 0; i++) begin @(posedge clk); #1; end
        chk("drain8", q8.size(), 0);
      end
    join

    @(posedge clk); #1;
    chk("ops32_in_order", done32, acc32);
    chk("ops8_in_order", done8, acc8);
    chk("ops8_exhaustive", acc8, 2048);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/shift_left_logical_iterative.md
# shift_left_logical_iterative

Multi-cycle logical left shifter, the left-direction companion to the combinational right shifter in the ALU datapath. It applies one binary-weighted shift stage per clock. Stage k shifts by 2^k when bit k of the shift amount is set, which trades area for a fixed latency of $clog2(N) cycles. Operands enter and results leave through valid/ready handshakes, so the block can sit behind a multi-cycle ALU controller or a pipelined execute stage.

## Interface
- N, default 32: data width; power of two, ≥ 2. L = $clog2(N) is the number of stages and the shamt width.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- in_valid  input  1  operand present on in/shamt.
- in_ready  output  1  block can accept an operand; high only in IDLE.
- in  input  N  value to shift.
- shamt  input  L  shift amount, unsigned, 0..N-1.
- out_valid  output  1  result present on out.
- out_ready  input  1  consumer accepts the result.
- out  output  N  result, equal to (in << shamt) with zero fill, truncated to N bits.

## Operation
- Internal registers:
  - acc[N-1:0]: working value.
  - sh[L-1:0]: latched shift amount.
  - k: stage counter, 0..L-1.
  - state: IDLE, SHIFT or DONE.
- IDLE:
  - in_ready = 1.
  - On a clock edge with in_valid = 1: acc ← in, sh ← shamt, k ← 0, next state SHIFT.
  - Otherwise the state holds.
- SHIFT:
  - Each cycle, if sh[k] = 1 then acc ← acc << 2^k (zero fill, drop MSBs); otherwise acc holds.
  - If k = L-1, next state is DONE. Otherwise k ← k+1.
  - in_ready = 0.
  - in_valid is ignored.
- DONE:
  - out_valid = 1, out = acc.
  - On an edge with out_ready = 1, next state is IDLE.
  - Otherwise the state holds; out and out_valid stay stable.
- out is driven from acc in every state. It is meaningful only while out_valid = 1.
- All L stages execute for every operand, including shamt = 0. There is no early exit.
- The operand is captured at the handshake edge. Changes on in/shamt after that edge do not affect the result.

## Timing
- Reset (rst = 0, asynchronous, immediate):
  - state = IDLE, acc = 0, sh = 0, k = 0.
  - out = 0, out_valid = 0, in_ready = 1.
  - No operand is accepted while rst = 0.
- Reset asserted mid-SHIFT or mid-DONE: the operation is discarded and no out_valid pulse is produced. After release the block is in IDLE and accepts an operand on the first edge with in_valid = 1.
- in_ready and out_valid are decoded directly from state registers. There is no combinational path from in_valid or out_ready to either output.
- Latency: operand accepted at edge 0; out_valid rises after edge L (L SHIFT cycles). For N = 32, out_valid is high in the cycle following edge 5.
- Throughput, with out_ready held high: one result every L+2 cycles.
  - L cycles in SHIFT.
  - 1 cycle in DONE.
  - 1 cycle in IDLE for the next accept.
- Backpressure: DONE holds indefinitely while out_ready = 0.
- Simultaneous in_valid and out_ready in DONE: only the result handshake completes. The new operand is taken in IDLE on a later edge.

## Test plan
- N = 32, in = 0x0000_0001, shamt = 31 → out_valid rises 5 cycles after accept with out = 0x8000_0000. in_ready = 0 throughout SHIFT.
- in = 0xDEAD_BEEF, shamt = 0 → out = 0xDEAD_BEEF, still after exactly 5 cycles. Then in = 0xFFFF_FFFF, shamt = 16 → out = 0xFFFF_0000. Then in = 0x1234_5678, shamt = 4 → out = 0x2345_6780.
- Backpressure: in = 0x0000_00F0, shamt = 8, with out_ready = 0 for 4 cycles in DONE → out = 0x0000_F000 is held stable and out_valid stays 1. An in_valid pulse with different data during this window is ignored. Raising out_ready → IDLE next cycle, and in_ready = 1.
- Reset mid-SHIFT: drop rst in the third SHIFT cycle → out_valid = 0, out = 0, in_ready = 1 immediately. After release, in = 0x0000_0003, shamt = 1 → out = 0x0000_0006 with normal latency.
- Randomized, ≥ 10 000 operands with random in_valid and out_ready stalls, compared against the reference model (in << shamt) & 0xFFFF_FFFF:
  - Every accepted operand produces exactly one result, in order.
  - Accept-to-valid latency is always 5 cycles.
  - Repeat the run at N = 8 with exhaustive in and shamt.
